// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg -- shared definitions for the program loader.
//
// Contents:
//   state_e          loader FSM states (CHK only with PROG_LOADER_CHECKSUM_EN)
//   NOP              instruction returned for unloaded / out-of-range fetches
//   ADD, SUB, LOAD   opcode field values of the 16-bit instruction
//                    {opcode[15:12], rd[11:8], rs1[7:4], rs2/imm[3:0]}
//   count_ok()       legality test for a frame count byte
//
// Configuration macro: PROG_LOADER_CHECKSUM_EN (adds the CHK state).
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HI     = 3'd1,
    ST_LO     = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd3,
`endif
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [3:0]  ADD  = 4'b0001;
  localparam logic [3:0]  SUB  = 4'b0010;
  localparam logic [3:0]  LOAD = 4'b0011;

  // A frame must carry between 1 and depth words.
  function automatic logic count_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && ({24'd0, n} <= 32'(depth));
  endfunction

endpackage

// File: rtl/prog_mem.sv
// ---------------------------------------------------------------------------
// prog_mem -- instruction word store, one write port, one registered read port.
//
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address (AW bits)
//   wr_data_i  16-bit word to write
//   rd_addr_i  read address (AW bits)
//   rd_data_o  word at rd_addr_i, one cycle later
//
// The array has no reset so it maps onto plain RAM; a read of the address
// being written in the same cycle returns the old contents.
// ---------------------------------------------------------------------------
module prog_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [15:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [15:0]   rd_data_o
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- receives a byte-serial program frame and serves instruction
// fetches from the committed image.
//
// Frame: count N (1..DEPTH), N words sent high byte first, then (with
// PROG_LOADER_CHECKSUM_EN) one checksum byte = XOR of count and data bytes.
//
// Ports:
//   clk          clock
//   reset        asynchronous reset, active low
//   in_valid     load byte presented
//   in_byte      load byte
//   in_ready     byte accepted on this edge when in_valid is high
//   fetch_addr   processor fetch address
//   fetch_instr  word[fetch_addr] one cycle later, NOP beyond prog_len
//   prog_len     number of committed words
//   load_busy    frame in progress
//   load_done    one-cycle pulse on successful commit
//   load_err     one-cycle pulse on rejected frame
//
// Configuration macro: PROG_LOADER_CHECKSUM_EN. AW must not exceed 7 since
// the count byte is 8 bits wide.
// ---------------------------------------------------------------------------
module prog_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [15:0]   fetch_instr,
  output logic [AW:0]   prog_len,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err
);

  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   prog_len_q;
  logic [AW-1:0] wr_ptr_q;
  logic [7:0]    hi_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          fetch_ok_q;
  logic [15:0]   rd_data;

  logic xfer;
  logic last_word;
  logic mem_we;

  assign xfer      = in_valid & ready_q;
  assign last_word = ({1'b0, wr_ptr_q} == (cnt_q - 1'b1));
  assign mem_we    = xfer && (state_q == ST_LO);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  assign csum_d = csum_q ^ in_byte;
`endif

  // in_ready is registered: it is cleared on the edge that enters COMMIT and
  // by reset, so it comes back high on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prog_len_q <= '0;
      wr_ptr_q   <= '0;
      hi_q       <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fetch_ok_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      // Range gate lines up with the registered RAM read.
      fetch_ok_q <= ({1'b0, fetch_addr} < prog_len_q);
      unique case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            prog_len_q <= '0;
            wr_ptr_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q     <= in_byte;
`endif
            if (count_ok(in_byte, DEPTH)) begin
              cnt_q   <= in_byte[AW:0];
              busy_q  <= 1'b1;
              state_q <= ST_HI;
            end else begin
              // Bad count: straight to COMMIT, pulse visible during it.
              err_q   <= 1'b1;
              ready_q <= 1'b0;
              state_q <= ST_COMMIT;
            end
          end
        end
        ST_HI: begin
          if (xfer) begin
            hi_q    <= in_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            state_q <= ST_LO;
          end
        end
        ST_LO: begin
          if (xfer) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
            if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_q    <= ST_CHK;
`else
              state_q    <= ST_COMMIT;
              ready_q    <= 1'b0;
              done_q     <= 1'b1;
              prog_len_q <= cnt_q;
`endif
            end else begin
              state_q <= ST_HI;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            state_q <= ST_COMMIT;
            ready_q <= 1'b0;
            if (in_byte == csum_q) begin
              done_q     <= 1'b1;
              prog_len_q <= cnt_q;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
`endif
        ST_COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({hi_q, in_byte}),
    .rd_addr_i (fetch_addr),
    .rd_data_o (rd_data)
  );

  assign fetch_instr = fetch_ok_q ? rd_data : NOP;
  assign in_ready    = ready_q;
  assign prog_len    = prog_len_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader -- self-checking bench for prog_loader. Frames come from a
// table of {bytes, expected outcome}; fetch results go through a scoreboard
// queue. Works with and without PROG_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic [AW-1:0] fetch_addr = '0;
  logic [15:0]   fetch_instr;
  logic [AW:0]   prog_len;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .prog_len    (prog_len),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Pulse / ready monitors, sampled on the falling edge.
  int done_cnt = 0;
  int err_cnt  = 0;
  int rdy_low  = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (load_done) done_cnt++;
      if (load_err)  err_cnt++;
      if (!in_ready) rdy_low++;
    end
  end

  // Reference image and fetch scoreboard.
  logic [15:0] model_mem [DEPTH];
  int          model_len = 0;
  logic [15:0] sb_q [$];

  function automatic logic [15:0] model_fetch(input int a);
    return (a < model_len) ? model_mem[a] : 16'h0000;
  endfunction

  task automatic fetch_sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      if (sb_q.size() > 0) check($sformatf("%s fetch", tag), fetch_instr, sb_q.pop_front());
      fetch_addr = AW'(a);
      sb_q.push_back(model_fetch(a));
    end
    @(negedge clk);
    check($sformatf("%s fetch", tag), fetch_instr, sb_q.pop_front());
  endtask

  // Presents one byte and returns on the falling edge after it transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout actual=%0h required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    string name;
    int    start;
    int    n;
    bit    ok;
    int    len;
    bit    gap;
  } vec_t;

  vec_t       vecs [$];
  logic [7:0] pool [$];

  task automatic add_vec(input string name, input logic [7:0] bs [$], input bit ok,
                         input int len, input bit gap);
    vec_t v;
    v.name = name; v.start = pool.size(); v.n = bs.size();
    v.ok = ok; v.len = len; v.gap = gap;
    foreach (bs[i]) pool.push_back(bs[i]);
    vecs.push_back(v);
  endtask

  task automatic run_frame(input vec_t v);
    bit busy_bad = 1'b0;
    @(negedge clk);
    done_cnt = 0; err_cnt = 0; rdy_low = 0;
    for (int i = 0; i < v.n; i++) begin
      send_byte(pool[v.start + i]);
      if (i < v.n - 1) begin
        if (!load_busy) busy_bad = 1'b1;
        if (i >= 1 && fetch_instr != 16'h0000) busy_bad = 1'b1;
        if (v.gap) begin
          @(negedge clk);
          if (!load_busy || fetch_instr != 16'h0000) busy_bad = 1'b1;
        end
      end
    end
    // Now inside the COMMIT cycle.
    check($sformatf("%s done@commit", v.name), load_done, v.ok);
    check($sformatf("%s err@commit", v.name), load_err, !v.ok);
    check($sformatf("%s ready@commit", v.name), in_ready, 0);
    repeat (3) @(negedge clk);
    check($sformatf("%s done pulses", v.name), done_cnt, v.ok ? 1 : 0);
    check($sformatf("%s err pulses", v.name), err_cnt, v.ok ? 0 : 1);
    check($sformatf("%s ready low cycles", v.name), rdy_low, 1);
    check($sformatf("%s prog_len", v.name), prog_len, v.len);
    check($sformatf("%s busy idle", v.name), load_busy, 0);
    if (v.n > 1) check($sformatf("%s busy/nop in frame", v.name), busy_bad, 0);
    if (v.ok) begin
      for (int k = 0; k < v.len; k++)
        model_mem[k] = {pool[v.start + 1 + 2*k], pool[v.start + 2 + 2*k]};
      model_len = v.len;
    end else begin
      model_len = 0;
    end
    fetch_sweep(v.name);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] f32 [$];

    // Stimulus table.
`ifdef PROG_LOADER_CHECKSUM_EN
    q = {8'h01, 8'h31, 8'h02, 8'h32};
`else
    q = {8'h01, 8'h31, 8'h02};
`endif
    add_vec("one_word", q, 1, 1, 0);
    f32 = {8'h04, 8'h11, 8'h23, 8'h24, 8'h12, 8'h35, 8'h02, 8'h16, 8'h51};
`ifdef PROG_LOADER_CHECKSUM_EN
    q = f32; q.push_back(8'h70);
    add_vec("four_words", q, 1, 4, 0);
    add_vec("four_gapped", q, 1, 4, 1);
    q = f32; q.push_back(8'h71);
    add_vec("bad_csum", q, 0, 0, 0);
`else
    add_vec("four_words", f32, 1, 4, 0);
    add_vec("four_gapped", f32, 1, 4, 1);
`endif
    q = {8'h00};
    add_vec("count_zero", q, 0, 0, 0);
    q = {8'h09};
    add_vec("count_nine", q, 0, 0, 0);
    q = {8'h08};
    for (int b = 8'h10; b <= 8'h1F; b++) q.push_back(8'(b));
`ifdef PROG_LOADER_CHECKSUM_EN
    q.push_back(8'h08);
`endif
    add_vec("full_eight", q, 1, 8, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    q = {8'h01, 8'h31, 8'h02, 8'h32};
`else
    q = {8'h01, 8'h31, 8'h02};
`endif
    add_vec("overwrite", q, 1, 1, 0);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst prog_len", prog_len, 0);
    check("rst fetch_instr", fetch_instr, 0);
    check("rst load_busy", load_busy, 0);
    check("rst load_done", load_done, 0);
    check("rst load_err", load_err, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post-rst in_ready", in_ready, 1);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset in the middle of a frame, then a full frame.
    @(negedge clk);
    for (int i = 0; i < 5; i++) send_byte(f32[i]);
    #2 reset = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst load_busy", load_busy, 0);
    check("midrst prog_len", prog_len, 0);
    check("midrst fetch_instr", fetch_instr, 0);
    model_len = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
